// File: rtl/dota_pkg.sv
// Shared types and constants for the OTA offset-calibration sequencer.
package dota_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StRun
    } state_e;

    // Comparator path is two flops deep, so a trim change needs at least this many cycles.
    localparam int unsigned MIN_SETTLE = 2;

    localparam int unsigned DefaultTrimW   = 6;
    localparam int unsigned DefaultSettleW = 4;
    localparam int unsigned DefaultRecalW  = 16;

endpackage

// File: rtl/dota_sync2.sv
// Two-flop synchronizer for the asynchronous comparator decision.
module dota_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dota_cal_ctrl.sv
// OTA offset-calibration sequencer: SAR search on the trim code using the shorted-input
// comparator decision, then run mode with optional periodic re-calibration.
module dota_cal_ctrl
    import dota_pkg::*;
#(
    parameter int unsigned TRIM_W   = DefaultTrimW,
    parameter int unsigned SETTLE_W = DefaultSettleW,
    parameter int unsigned RECAL_W  = DefaultRecalW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena_i,
    input  logic                cal_start_i,
    input  logic [SETTLE_W-1:0] settle_cycles_i,
    input  logic [RECAL_W-1:0]  recal_period_i,
    input  logic                cmp_in_i,
    output logic                ota_en_o,
    output logic                cal_mode_o,
    output logic [TRIM_W-1:0]   trim_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                trim_valid_o
);

    localparam int unsigned IdxW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] TrimMsb = TRIM_W'(1) << (TRIM_W - 1);

    state_e              state_q, state_d;
    logic [TRIM_W-1:0]   trim_q, trim_d;
    logic                trim_valid_q, trim_valid_d;
    logic                ota_en_q, ota_en_d;
    logic                cal_mode_q, cal_mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [RECAL_W-1:0]  recal_cnt_q, recal_cnt_d;

    logic                cmp_s;
    logic                start_cal;
    logic                recal_expire;
    logic [SETTLE_W-1:0] settle_load;
    logic [TRIM_W-1:0]   trim_n;

    dota_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in_i),
        .q_o   (cmp_s)
    );

    // Counter is loaded with S-1 and SETTLE exits at zero, giving exactly S cycles.
    always_comb begin
        if (settle_cycles_i < SETTLE_W'(MIN_SETTLE)) begin
            settle_load = SETTLE_W'(MIN_SETTLE - 1);
        end else begin
            settle_load = settle_cycles_i - SETTLE_W'(1);
        end
    end

    assign recal_expire = (recal_period_i != '0) &&
                          (recal_cnt_q == recal_period_i - RECAL_W'(1));

    always_comb begin
        state_d      = state_q;
        trim_d       = trim_q;
        trim_valid_d = trim_valid_q;
        ota_en_d     = ota_en_q;
        cal_mode_d   = cal_mode_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        settle_cnt_d = settle_cnt_q;
        bit_idx_d    = bit_idx_q;
        recal_cnt_d  = recal_cnt_q;
        start_cal    = 1'b0;
        trim_n       = trim_q;

        unique case (state_q)
            StIdle: begin
                start_cal = cal_start_i;
            end
            StSettle: begin
                if (settle_cnt_q == '0) begin
                    state_d = StSample;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end
            StSample: begin
                if (cmp_s) begin
                    trim_n[bit_idx_q] = 1'b0;
                end
                if (bit_idx_q != '0) begin
                    trim_n[bit_idx_q - IdxW'(1)] = 1'b1;
                    bit_idx_d    = bit_idx_q - IdxW'(1);
                    settle_cnt_d = settle_load;
                    state_d      = StSettle;
                end else begin
                    state_d      = StRun;
                    done_d       = 1'b1;
                    trim_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    cal_mode_d   = 1'b0;
                    recal_cnt_d  = '0;
                end
                trim_d = trim_n;
            end
            StRun: begin
                recal_cnt_d = recal_cnt_q + RECAL_W'(1);
                start_cal   = cal_start_i || recal_expire;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_cal) begin
            state_d      = StSettle;
            trim_d       = TrimMsb;
            bit_idx_d    = IdxW'(TRIM_W - 1);
            settle_cnt_d = settle_load;
            busy_d       = 1'b1;
            trim_valid_d = 1'b0;
            ota_en_d     = 1'b1;
            cal_mode_d   = 1'b1;
            recal_cnt_d  = '0;
        end

        // Disable overrides everything; only a finished result survives it.
        if (!ena_i) begin
            state_d      = StIdle;
            ota_en_d     = 1'b0;
            cal_mode_d   = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            settle_cnt_d = '0;
            bit_idx_d    = '0;
            recal_cnt_d  = '0;
            if ((state_q == StSettle) || (state_q == StSample)) begin
                trim_d       = '0;
                trim_valid_d = 1'b0;
            end else begin
                trim_d       = trim_q;
                trim_valid_d = trim_valid_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            trim_q       <= '0;
            trim_valid_q <= 1'b0;
            ota_en_q     <= 1'b0;
            cal_mode_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            settle_cnt_q <= '0;
            bit_idx_q    <= '0;
            recal_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            trim_q       <= trim_d;
            trim_valid_q <= trim_valid_d;
            ota_en_q     <= ota_en_d;
            cal_mode_q   <= cal_mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            settle_cnt_q <= settle_cnt_d;
            bit_idx_q    <= bit_idx_d;
            recal_cnt_q  <= recal_cnt_d;
        end
    end

    assign ota_en_o     = ota_en_q;
    assign cal_mode_o   = cal_mode_q;
    assign trim_o       = trim_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign trim_valid_o = trim_valid_q;

endmodule

// File: tb/tb_dota_cal_ctrl.sv
// Scoreboard bench for dota_cal_ctrl: threshold comparator model, expected SAR results queued.
module tb_dota_cal_ctrl;

    localparam int TW = 6;
    localparam int SW = 4;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          cal_start = 1'b0;
    logic [SW-1:0] settle_cycles = '0;
    logic [RW-1:0] recal_period = '0;
    logic          cmp_in;
    logic          ota_en, cal_mode, busy, done, trim_valid;
    logic [TW-1:0] trim;

    int thr = 37;
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    bit done_prev = 1'b0;

    typedef struct {
        int trim;
        int lat;
        int start;
    } exp_t;
    exp_t sb[$];

    // Offset model: comparator trips when trim exceeds the OTA's true offset code.
    assign cmp_in = (int'(trim) > thr);

    dota_cal_ctrl #(.TRIM_W(TW), .SETTLE_W(SW), .RECAL_W(RW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena_i           (ena),
        .cal_start_i     (cal_start),
        .settle_cycles_i (settle_cycles),
        .recal_period_i  (recal_period),
        .cmp_in_i        (cmp_in),
        .ota_en_o        (ota_en),
        .cal_mode_o      (cal_mode),
        .trim_o          (trim),
        .busy_o          (busy),
        .done_o          (done),
        .trim_valid_o    (trim_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_total = n_total + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic int ref_trim(input int t);
        if (t < 0) return 0;
        if (t > (1 << TW) - 1) return (1 << TW) - 1;
        return t;
    endfunction

    function automatic int ref_lat(input int s);
        int se;
        se = (s < 2) ? 2 : s;
        return TW * (se + 1) + 1;
    endfunction

    // Monitor: every done pulse must match the oldest expected calibration.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            chk("done_pulse_width", int'(done_prev), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("final_trim", int'(trim), e.trim);
                chk("done_latency", cyc - e.start, e.lat);
                chk("trim_valid_at_done", int'(trim_valid), 1);
                chk("busy_at_done", int'(busy), 0);
                chk("cal_mode_at_done", int'(cal_mode), 0);
                chk("ota_en_at_done", int'(ota_en), 1);
            end
        end
        done_prev = done;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Pulses cal_start for one cycle; cyc now is the edge before the sampling edge.
    task automatic issue(input bit push, input int t, input int s);
        exp_t e;
        if (push) begin
            e.trim  = ref_trim(t);
            e.lat   = ref_lat(s);
            e.start = cyc;
            sb.push_back(e);
        end
        cal_start = 1'b1;
        tick(1);
        cal_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int done_cyc);
        bit seen;
        seen = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        chk("done_within_bound", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int d;
        int s;
        tick(2);
        chk("rst_ota_en", int'(ota_en), 0);
        chk("rst_cal_mode", int'(cal_mode), 0);
        chk("rst_trim", int'(trim), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_trim_valid", int'(trim_valid), 0);
        rst_n = 1'b1;
        ena = 1'b1;
        tick(2);

        // Nominal SAR, offset 37, S=4.
        thr = 37;
        settle_cycles = 4'd4;
        issue(1'b1, thr, 4);
        chk("cal_first_trim", int'(trim), 32);
        chk("cal_first_busy", int'(busy), 1);
        chk("cal_first_cal_mode", int'(cal_mode), 1);
        chk("cal_first_ota_en", int'(ota_en), 1);
        wait_done(200, d);
        tick(3);
        chk("run_trim_hold", int'(trim), 37);
        chk("run_cal_mode", int'(cal_mode), 0);

        // Settle clamp: 0 and 1 both behave as 2; restart issued from RUN.
        settle_cycles = 4'd0;
        issue(1'b1, thr, 0);
        wait_done(200, d);
        settle_cycles = 4'd1;
        issue(1'b1, thr, 1);
        wait_done(200, d);

        // Edge codes.
        settle_cycles = 4'd3;
        thr = -1;
        issue(1'b1, thr, 3);
        wait_done(200, d);
        thr = 100;
        issue(1'b1, thr, 3);
        wait_done(200, d);

        // Random offsets and settle times, with an ignored cal_start while busy.
        for (int k = 0; k < 8; k++) begin
            s = int'($urandom_range(0, 9));
            thr = int'($urandom_range(0, 70)) - 1;
            settle_cycles = SW'(s);
            issue(1'b1, thr, s);
            tick(int'($urandom_range(1, 12)));
            cal_start = 1'b1;
            tick(1);
            cal_start = 1'b0;
            wait_done(300, d);
        end

        // Auto re-calibration 100 RUN cycles after done; offset moves to 10.
        settle_cycles = 4'd4;
        thr = 37;
        recal_period = 16'd100;
        issue(1'b1, thr, 4);
        wait_done(200, d);
        thr = 10;
        begin
            exp_t e;
            e.trim = ref_trim(10);
            e.lat = ref_lat(4);
            e.start = d + 100 - 1;
            sb.push_back(e);
        end
        wait_done(300, d);
        recal_period = 16'd0;
        tick(2);
        chk("recal_trim", int'(trim), 10);

        // Abort during bit 3.
        thr = 20;
        issue(1'b0, thr, 4);
        tick(2 * 5 + 2);
        ena = 1'b0;
        tick(1);
        chk("abort_trim", int'(trim), 0);
        chk("abort_trim_valid", int'(trim_valid), 0);
        chk("abort_ota_en", int'(ota_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cal_mode", int'(cal_mode), 0);
        ena = 1'b1;
        tick(2);

        // Disable from RUN keeps the finished result.
        thr = 45;
        issue(1'b1, thr, 4);
        wait_done(200, d);
        ena = 1'b0;
        tick(2);
        chk("idle_keep_trim", int'(trim), 45);
        chk("idle_keep_valid", int'(trim_valid), 1);
        chk("idle_ota_en", int'(ota_en), 0);
        ena = 1'b1;

        // Asynchronous reset mid-calibration.
        issue(1'b0, thr, 4);
        tick(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ota_en", int'(ota_en), 0);
        chk("arst_cal_mode", int'(cal_mode), 0);
        chk("arst_trim", int'(trim), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_trim_valid", int'(trim_valid), 0);
        tick(2);
        rst_n = 1'b1;
        tick(60);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_ota_en", int'(ota_en), 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
